sha256_msg_server: RTL and testbench
====================================

# sha256_msg_server

Bus responder feeding 512-bit message chunks to `sha256_stream` over its `rq`/`rdy`/`addr`/`data` word-fetch interface. It holds a byte-loaded 76-byte Bitcoin header prefix and a 32-bit nonce counter, and serves any of three chunks on demand, with SHA-256 padding generated on the fly:
- header chunk 0;
- header tail + nonce chunk 1;
- second-pass digest chunk 2.

It sits between the host load path and the hash core, so the core never needs a full message RAM.

## Interface
- `LEN_CHUNK1`, default 640: bit length written to word 15 of chunk 1 (80-byte header).
- `LEN_CHUNK2`, default 256: bit length written to word 15 of chunk 2 (32-byte digest).

Ports:
- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `load_valid`  in  1  write `load_byte` at the current load pointer.
- `load_byte`  in  8  header byte, in serialization order.
- `load_restart`  in  1  return the load pointer to 0 and clear `hdr_ready`.
- `hdr_ready`  out  1  all 76 prefix bytes loaded.
- `nonce_inc`  in  1  nonce += 1 (mod 2^32).
- `nonce_clr`  in  1  nonce <= 0.
- `nonce`  out  32  current nonce.
- `mode`  in  2  chunk select: 0, 1, 2; 3 = reserved.
- `digest_in`  in  256  first-pass digest {H0..H7}, H0 in bits [255:224].
- `rq`  in  1  word request from the hash core.
- `addr`  in  4  requested word index 0..15.
- `rdy`  out  1  one-cycle pulse; `data` valid.
- `data`  out  32  requested word.
- `chunk_done`  out  1  one-cycle pulse alongside the `rdy` that returns word 15.

## Operation
- Header store: 19 words, hw[0..18]. Byte k goes to hw[k/4], big-endian within the word: byte 4j lands in [31:24].
- Load pointer `lp` (7 bits) counts 0..76.
  - `load_valid` with `lp`<76: write the byte, `lp`++.
  - `load_valid` with `lp`==76: byte ignored (no wrap).
  - `hdr_ready` = (`lp`==76), registered.
- `load_restart` beats `load_valid` in the same cycle: `lp`<=0 and the byte is dropped. Stored bytes are retained, not cleared.
- `nonce_clr` beats `nonce_inc` in the same cycle. 0xFFFFFFFF + 1 wraps to 0.
- Word map, with `ns` = byte-swapped nonce {n[7:0],n[15:8],n[23:16],n[31:24]}:
  - mode 0: word a = hw[a].
  - mode 1: a=0..2 → hw[16+a]; a=3 → `ns`; a=4 → 0x80000000; a=5..14 → 0; a=15 → `LEN_CHUNK1`.
  - mode 2: a=0..7 → digest word a (H0 first); a=8 → 0x80000000; a=9..14 → 0; a=15 → `LEN_CHUNK2`.
  - mode 3: every word is 0. The handshake still completes, so the requester never hangs.
- Serving is independent of `hdr_ready`. An incomplete header serves whatever is stored.

## Timing
- Reset values: `rdy`=0, `data`=0, `chunk_done`=0, `hdr_ready`=0, `nonce`=0, `lp`=0. Header store contents are undefined after reset.
- Handshake, fully registered:
  - When `rq`=1 and `rdy`=0 at edge N: `rdy`=1 after N, and `data` = word(`mode`,`addr`) using values sampled at N.
  - `rdy` then drops after N+1 regardless of `rq`. The requester's `rq` is still high in the cycle it sees `rdy`, and this rule prevents a double response.
  - Latency: 1 cycle from `rq` sample to `rdy`. The cadence with `sha256_stream` is 3 cycles per word, 48 cycles per chunk.
- `data` holds its last value while `rdy`=0.
- `chunk_done` is asserted in the same cycle as `rdy` when the served `addr` was 15.
- Simultaneous events:
  - A load write or nonce update at edge N is not visible in a word captured at N. The served word uses pre-update values.
  - `mode` or `digest_in` changing mid-chunk affects only words captured afterwards.
- `rst` mid-chunk: `rdy` and `chunk_done` drop on the next edge, and the pending request is discarded. An `rq` asserted during the `rst` cycle is not answered.

## Test plan
- Load bytes 0x00..0x4B, mode 0, drive the `sha256_stream`-style handshake for addr 0..15:
  - hw[0]=0x00010203, hw[15]=0x3C3D3E3F;
  - `hdr_ready` rises after the 76th byte;
  - `rdy` never high two cycles in a row.
- Same header, `nonce_clr` then 3× `nonce_inc`, mode 1:
  - word 3 = 0x03000000, word 4 = 0x80000000, word 15 = 0x00000280;
  - `chunk_done` pulses with word 15 only.
- `digest_in` = {0x11111111 … 0x88888888}, mode 2: words 0..7 match, word 8 = 0x80000000, word 15 = 0x00000100.
- Simultaneous events:
  - `nonce_inc` and `nonce_clr` in the same cycle → nonce=0;
  - nonce 0xFFFFFFFF + `nonce_inc` → 0;
  - `load_restart` and `load_valid` together → `lp`=0, `hdr_ready`=0;
  - a 77th byte is ignored.
- Mode 3: every requested word returns 0x00000000 and the handshake completes.
- Assert `rst` one cycle after `rq`: `rdy` stays 0 and all outputs return to reset values. After release, a fresh request is answered 1 cycle after `rq`.

Source files
------------

// File: rtl/sha256_msg_server.sv
`default_nettype none
// ============================================================================
// Module   : sha256_msg_server
// Purpose  : Word-fetch responder that serves 512-bit SHA-256 message chunks
//            to a hash core. It holds a byte-loaded 76-byte header prefix
//            and a 32-bit nonce counter. Padding and length words are
//            generated on the fly, so the core needs no full message RAM.
//              mode 0 : header chunk 0 (header words 0..15)
//              mode 1 : header tail + byte-swapped nonce + padding
//              mode 2 : first-pass digest + padding (second pass)
//              mode 3 : reserved, every word reads as zero
// Ports    : clk, rst                 - clock, synchronous active-high reset
//            load_valid/byte/restart  - serial header byte load path
//            hdr_ready                - all 76 prefix bytes are loaded
//            nonce_inc/clr, nonce     - nonce counter control and value
//            mode, digest_in          - chunk select, first-pass digest
//            rq, addr, rdy, data      - word request/response handshake
//            chunk_done               - pulses together with the word-15 rdy
// Revision : 1.0 - initial release
// ============================================================================
module sha256_msg_server #(
  parameter int LEN_CHUNK1 = 640,
  parameter int LEN_CHUNK2 = 256
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_valid,
  input  logic [7:0]   load_byte,
  input  logic         load_restart,
  output logic         hdr_ready,
  input  logic         nonce_inc,
  input  logic         nonce_clr,
  output logic [31:0]  nonce,
  input  logic [1:0]   mode,
  input  logic [255:0] digest_in,
  input  logic         rq,
  input  logic [3:0]   addr,
  output logic         rdy,
  output logic [31:0]  data,
  output logic         chunk_done
);

  localparam logic [6:0]  HDR_BYTES = 7'd76;
  localparam logic [31:0] PAD_WORD  = 32'h8000_0000;

  // Header store: 19 big-endian words. Not reset, so no reset fan-out here.
  logic [31:0] hw [0:18];
  logic [6:0]  lp;
  logic [31:0] nonce_swapped;
  logic [31:0] word;
  logic        load_write;

  // A restart in the same cycle drops the byte. A full store ignores bytes.
  assign load_write = load_valid && !load_restart && (lp < HDR_BYTES);

  always_ff @(posedge clk) begin
    if (load_write) begin
      case (lp[1:0])
        2'd0:    hw[lp[6:2]][31:24] <= load_byte;
        2'd1:    hw[lp[6:2]][23:16] <= load_byte;
        2'd2:    hw[lp[6:2]][15:8]  <= load_byte;
        default: hw[lp[6:2]][7:0]   <= load_byte;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lp        <= 7'd0;
      hdr_ready <= 1'b0;
    end else if (load_restart) begin
      lp        <= 7'd0;
      hdr_ready <= 1'b0;
    end else if (load_write) begin
      lp        <= lp + 7'd1;
      hdr_ready <= (lp == HDR_BYTES - 7'd1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst || nonce_clr) begin
      nonce <= 32'h0;
    end else if (nonce_inc) begin
      nonce <= nonce + 32'h1;
    end
  end

  // The nonce sits little-endian in the header, but words are read big-endian.
  assign nonce_swapped = {nonce[7:0], nonce[15:8], nonce[23:16], nonce[31:24]};

  always_comb begin
    word = 32'h0;
    case (mode)
      2'd0: word = hw[addr];
      2'd1: begin
        case (addr)
          4'd0:    word = hw[16];
          4'd1:    word = hw[17];
          4'd2:    word = hw[18];
          4'd3:    word = nonce_swapped;
          4'd4:    word = PAD_WORD;
          4'd15:   word = 32'(LEN_CHUNK1);
          default: word = 32'h0;
        endcase
      end
      2'd2: begin
        case (addr)
          4'd0:    word = digest_in[255:224];
          4'd1:    word = digest_in[223:192];
          4'd2:    word = digest_in[191:160];
          4'd3:    word = digest_in[159:128];
          4'd4:    word = digest_in[127:96];
          4'd5:    word = digest_in[95:64];
          4'd6:    word = digest_in[63:32];
          4'd7:    word = digest_in[31:0];
          4'd8:    word = PAD_WORD;
          4'd15:   word = 32'(LEN_CHUNK2);
          default: word = 32'h0;
        endcase
      end
      default: word = 32'h0;
    endcase
  end

  // The requester still holds rq in the cycle it sees rdy. Answering only when
  // rdy is low forces rdy to drop after one cycle and blocks a double reply.
  always_ff @(posedge clk) begin
    if (rst) begin
      rdy        <= 1'b0;
      data       <= 32'h0;
      chunk_done <= 1'b0;
    end else if (rq && !rdy) begin
      rdy        <= 1'b1;
      data       <= word;
      chunk_done <= (addr == 4'd15);
    end else begin
      rdy        <= 1'b0;
      chunk_done <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_sha256_msg_server.sv
`default_nettype none
// ============================================================================
// Module   : tb_sha256_msg_server
// Purpose  : Self-checking bench for sha256_msg_server. A byte-level model of
//            the served chunks is compared with the DUT on every cycle.
//            Directed requests are checked against hand-computed literals.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sha256_msg_server;

  logic         clk = 1'b0;
  logic         rst;
  logic         load_valid;
  logic [7:0]   load_byte;
  logic         load_restart;
  logic         hdr_ready;
  logic         nonce_inc;
  logic         nonce_clr;
  logic [31:0]  nonce;
  logic [1:0]   mode;
  logic [255:0] digest_in;
  logic         rq;
  logic [3:0]   addr;
  logic         rdy;
  logic [31:0]  data;
  logic         chunk_done;

  int errors = 0;
  int checks = 0;

  sha256_msg_server #(.LEN_CHUNK1(640), .LEN_CHUNK2(256)) dut (
    .clk(clk), .rst(rst),
    .load_valid(load_valid), .load_byte(load_byte), .load_restart(load_restart),
    .hdr_ready(hdr_ready),
    .nonce_inc(nonce_inc), .nonce_clr(nonce_clr), .nonce(nonce),
    .mode(mode), .digest_in(digest_in),
    .rq(rq), .addr(addr), .rdy(rdy), .data(data), .chunk_done(chunk_done)
  );

  always #5 clk = ~clk;

  function automatic void chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", nm, got, exp);
    end
  endfunction

  // ---------------- behavioural model (byte-level message view) ------------
  logic [7:0]  hb [0:75];
  int          m_lp;
  logic [31:0] m_nonce;
  logic        m_rdy, m_cd;
  logic [31:0] m_data;
  bit          mon_on = 1'b0;
  logic        prev_rdy = 1'b0;

  function automatic logic [31:0] exp_word(input logic [1:0] md, input logic [3:0] a);
    int i;
    i = int'(a);
    case (md)
      2'd0: return {hb[4*i], hb[4*i+1], hb[4*i+2], hb[4*i+3]};
      2'd1: begin
        if (i < 3) return {hb[64+4*i], hb[65+4*i], hb[66+4*i], hb[67+4*i]};
        if (i == 3) return {m_nonce[7:0], m_nonce[15:8], m_nonce[23:16], m_nonce[31:24]};
        if (i == 4) return 32'h8000_0000;
        if (i == 15) return 32'd640;
        return 32'h0;
      end
      2'd2: begin
        if (i < 8) return digest_in[255 - 32*i -: 32];
        if (i == 8) return 32'h8000_0000;
        if (i == 15) return 32'd256;
        return 32'h0;
      end
      default: return 32'h0;
    endcase
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_rdy = 1'b0; m_cd = 1'b0; m_data = 32'h0; m_lp = 0; m_nonce = 32'h0;
    end else begin
      if (rq && !m_rdy) begin
        m_data = exp_word(mode, addr);
        m_rdy  = 1'b1;
        m_cd   = (addr == 4'd15);
      end else begin
        m_rdy = 1'b0;
        m_cd  = 1'b0;
      end
      if (load_restart) m_lp = 0;
      else if (load_valid && m_lp < 76) begin
        hb[m_lp] = load_byte;
        m_lp++;
      end
      if (nonce_clr) m_nonce = 32'h0;
      else if (nonce_inc) m_nonce = m_nonce + 32'h1;
    end
  end

  // ---------------- per-cycle compare ------------------------------------
  always @(posedge clk) begin
    #1;
    if (mon_on) begin
      chk("mon_rdy",        {31'b0, rdy},        {31'b0, m_rdy});
      chk("mon_data",       data,                m_data);
      chk("mon_chunk_done", {31'b0, chunk_done}, {31'b0, m_cd});
      chk("mon_hdr_ready",  {31'b0, hdr_ready},  {31'b0, (m_lp == 76)});
      chk("mon_nonce",      nonce,               m_nonce);
      chk("rdy_back2back",  {31'b0, rdy && prev_rdy}, 32'h0);
      prev_rdy = rdy;
    end
  end

  // ---------------- stimulus tasks (enter and leave at a negedge) ---------
  task automatic load_b(input logic [7:0] b);
    load_valid = 1'b1;
    load_byte  = b;
    @(negedge clk);
    load_valid = 1'b0;
  endtask

  task automatic req(input logic [3:0] a, output logic [31:0] d, output logic cd);
    int n;
    n    = 0;
    rq   = 1'b1;
    addr = a;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!rdy && n < 8);
    if (!rdy) begin
      errors++; checks++;
      $display("FAIL req_timeout: got no rdy expected rdy within 8 cycles");
      d  = 'x;
      cd = 1'bx;
    end else begin
      chk("req_latency", n, 32'd1);
      d  = data;
      cd = chunk_done;
    end
    @(negedge clk);
    rq = 1'b0;
    @(negedge clk);
  endtask

  task automatic run_chunk(input string nm, input logic [31:0] exp [0:15]);
    logic [31:0] d;
    logic        cd;
    for (int a = 0; a < 16; a++) begin
      req(4'(a), d, cd);
      chk({nm, "_word"}, d, exp[a]);
      chk({nm, "_chunk_done"}, {31'b0, cd}, {31'b0, (a == 15)});
    end
  endtask

  // ---------------- directed sequence ------------------------------------
  logic [31:0] expw [0:15];
  logic [31:0] d;
  logic        cd;
  logic [7:0]  bb;

  initial begin
    rst = 1'b1; load_valid = 1'b0; load_byte = 8'h0; load_restart = 1'b0;
    nonce_inc = 1'b0; nonce_clr = 1'b0; mode = 2'd0; digest_in = '0;
    rq = 1'b0; addr = 4'd0;
    repeat (3) @(negedge clk);
    chk("reset_rdy",        {31'b0, rdy},        32'h0);
    chk("reset_data",       data,                32'h0);
    chk("reset_chunk_done", {31'b0, chunk_done}, 32'h0);
    chk("reset_hdr_ready",  {31'b0, hdr_ready},  32'h0);
    chk("reset_nonce",      nonce,               32'h0);
    mon_on = 1'b1;
    rst    = 1'b0;
    @(negedge clk);

    // Header bytes 0x00..0x4B.
    for (int i = 0; i < 76; i++) begin
      load_b(8'(i));
      if (i == 74) chk("hdr_ready_75", {31'b0, hdr_ready}, 32'h0);
    end
    chk("hdr_ready_76", {31'b0, hdr_ready}, 32'h1);

    // Mode 0: word a = bytes 4a..4a+3.
    mode = 2'd0;
    for (int a = 0; a < 16; a++) begin
      bb = 8'(4 * a);
      expw[a] = {bb, bb + 8'd1, bb + 8'd2, bb + 8'd3};
    end
    run_chunk("mode0", expw);
    req(4'd0, d, cd);  chk("hw0_literal", d, 32'h0001_0203);
    req(4'd15, d, cd); chk("hw15_literal", d, 32'h3C3D_3E3F);

    // Nonce = 3, mode 1.
    nonce_clr = 1'b1; @(negedge clk); nonce_clr = 1'b0;
    nonce_inc = 1'b1; repeat (3) @(negedge clk); nonce_inc = 1'b0;
    chk("nonce_3", nonce, 32'd3);
    mode = 2'd1;
    for (int a = 0; a < 16; a++) expw[a] = 32'h0;
    expw[0] = 32'h4041_4243; expw[1] = 32'h4445_4647; expw[2] = 32'h4849_4A4B;
    expw[3] = 32'h0300_0000; expw[4] = 32'h8000_0000; expw[15] = 32'h0000_0280;
    run_chunk("mode1", expw);

    // Mode 2 with a patterned digest.
    digest_in = 256'h11111111_22222222_33333333_44444444_55555555_66666666_77777777_88888888;
    mode = 2'd2;
    for (int a = 0; a < 16; a++) expw[a] = 32'h0;
    for (int a = 0; a < 8; a++) expw[a] = 32'h1111_1111 * (a + 1);
    expw[8] = 32'h8000_0000; expw[15] = 32'h0000_0100;
    run_chunk("mode2", expw);

    // Clear beats increment.
    nonce_inc = 1'b1; @(negedge clk);
    nonce_clr = 1'b1; @(negedge clk);
    nonce_inc = 1'b0; nonce_clr = 1'b0;
    chk("nonce_clr_beats_inc", nonce, 32'h0);

    // Restart beats a load; the dropped byte must not overwrite byte 0.
    load_restart = 1'b1; load_valid = 1'b1; load_byte = 8'hEE;
    @(negedge clk);
    load_restart = 1'b0; load_valid = 1'b0;
    chk("restart_hdr_ready", {31'b0, hdr_ready}, 32'h0);
    mode = 2'd0;
    req(4'd0, d, cd); chk("restart_byte_dropped", d, 32'h0001_0203);

    // Reload 0x80..0xCB, then a 77th byte that must be ignored.
    for (int i = 0; i < 76; i++) load_b(8'(8'h80 + i));
    chk("reload_hdr_ready", {31'b0, hdr_ready}, 32'h1);
    load_b(8'hFF);
    chk("byte77_hdr_ready", {31'b0, hdr_ready}, 32'h1);
    req(4'd0, d, cd); chk("reload_word0", d, 32'h8081_8283);
    mode = 2'd1;
    req(4'd2, d, cd); chk("byte77_ignored", d, 32'hC8C9_CACB);

    // Mode 3: all zero, handshake still completes.
    mode = 2'd3;
    for (int a = 0; a < 16; a++) expw[a] = 32'h0;
    run_chunk("mode3", expw);

    // Reset in the middle of a served word, with rq still held.
    mode = 2'd1; nonce_inc = 1'b1; @(negedge clk); nonce_inc = 1'b0;
    rq = 1'b1; addr = 4'd15;
    @(posedge clk); #1;
    chk("pre_rst_rdy", {31'b0, rdy}, 32'h1);
    chk("pre_rst_chunk_done", {31'b0, chunk_done}, 32'h1);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("rst_rdy",        {31'b0, rdy},        32'h0);
    chk("rst_chunk_done", {31'b0, chunk_done}, 32'h0);
    chk("rst_data",       data,                32'h0);
    chk("rst_nonce",      nonce,               32'h0);
    chk("rst_hdr_ready",  {31'b0, hdr_ready},  32'h0);
    @(posedge clk); #1;
    chk("rst_rq_ignored", {31'b0, rdy}, 32'h0);
    @(negedge clk);
    rst = 1'b0; rq = 1'b0;
    @(negedge clk);
    chk("post_rst_idle", {31'b0, rdy}, 32'h0);
    req(4'd4, d, cd); chk("post_rst_word", d, 32'h8000_0000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before 200000");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
